// File: rtl/int_vector_responder_pkg.sv
// Shared constants, state type and level decode helper for the 68k interrupt vector responder.
// Imported by the edge latch and the top level.
package int_pkg;

   localparam int unsigned NUM_LEVELS   = 7;
   localparam logic [7:0]  SPURIOUS_VEC = 8'h18;
   localparam logic [7:0]  AUTOVEC_BASE = 8'h18;

   typedef enum logic [1:0] {
      StIdle,
      StAck,
      StHold
   } state_e;

   // One-hot of level lvl (bit lvl-1); level 0 is invalid and decodes to all-zero.
   function automatic logic [NUM_LEVELS-1:0] level_onehot(input logic [2:0] lvl);
      logic [NUM_LEVELS-1:0] oh;
      oh = '0;
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
         if ({29'b0, lvl} == i + 32'd1) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/int_vector_responder_irq_edge_latch.sv
// Latches rising edges of the interrupt request lines into pending bits.
// A new edge on a bit wins over a clear of that same bit in the same cycle.
module irq_edge_latch
   import int_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_LEVELS-1:0] irq_i,
   input  logic [NUM_LEVELS-1:0] clr_mask_i,
   output logic [NUM_LEVELS-1:0] pending_o
);

   logic [NUM_LEVELS-1:0] irq_r_q, irq_r_d;
   logic [NUM_LEVELS-1:0] pending_q, pending_d;
   logic [NUM_LEVELS-1:0] rise;

   always_comb begin
      rise      = irq_i & ~irq_r_q;
      irq_r_d   = irq_i;
      pending_d = (pending_q & ~clr_mask_i) | rise;
   end

   // irq_r clears in reset so a line held high through release counts as an edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         irq_r_q   <= '0;
         pending_q <= '0;
      end else begin
         irq_r_q   <= irq_r_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/int_vector_responder.sv
// Answers 68k IACK cycles on the Wishbone side with a vectored, autovectored or spurious
// vector number and retires the acknowledged pending interrupt.
module int_vector_responder
   import int_pkg::*;
#(
   parameter logic [7:0]            VECTOR_BASE = 8'h40,
   parameter logic [NUM_LEVELS-1:0] AUTOVEC     = '0
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_reset_ni,
   input  logic [NUM_LEVELS-1:0] irq_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_iack_i,
   input  logic [2:0]            wb_adr_i,
   output logic [7:0]            wb_dat_o,
   output logic                  wb_ack_o,
   output logic [NUM_LEVELS-1:0] pending_o
);

   state_e                state_q, state_d;
   logic [2:0]            lvl_q, lvl_d;
   logic                  hit_q, hit_d;
   logic [7:0]            dat_q, dat_d;

   logic [NUM_LEVELS-1:0] pending;
   logic [NUM_LEVELS-1:0] clr_mask;
   logic [NUM_LEVELS-1:0] req_onehot;
   logic                  bus_req;
   logic                  iack_req;
   logic                  sel_hit;
   logic [7:0]            sel_vec;

   irq_edge_latch u_irq_edge_latch (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_reset_ni),
      .irq_i      (irq_i),
      .clr_mask_i (clr_mask),
      .pending_o  (pending)
   );

   assign bus_req    = wb_cyc_i & wb_stb_i;
   assign iack_req   = bus_req & wb_iack_i;
   assign req_onehot = level_onehot(wb_adr_i);

   // Vector for the level currently on the address lines; wraps at 8 bits.
   always_comb begin
      sel_hit = |(req_onehot & pending);
      if (!sel_hit) begin
         sel_vec = SPURIOUS_VEC;
      end else if (|(req_onehot & AUTOVEC)) begin
         sel_vec = AUTOVEC_BASE + {5'b0, wb_adr_i};
      end else begin
         sel_vec = VECTOR_BASE + {5'b0, wb_adr_i} - 8'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      lvl_d    = lvl_q;
      hit_d    = hit_q;
      dat_d    = dat_q;
      clr_mask = '0;
      wb_ack_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (iack_req) begin
               lvl_d   = wb_adr_i;
               hit_d   = sel_hit;
               dat_d   = sel_vec;
               state_d = StAck;
            end
         end
         StAck: begin
            wb_ack_o = bus_req;
            if (bus_req) begin
               if (hit_q) begin
                  clr_mask = level_onehot(lvl_q);
               end
               state_d = StHold;
            end else begin
               // Master abandoned the cycle before the ack: keep the request pending.
               state_d = StIdle;
            end
         end
         StHold: begin
            if (!bus_req) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_reset_ni) begin
         state_q <= StIdle;
         lvl_q   <= '0;
         hit_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         hit_q   <= hit_d;
         dat_q   <= dat_d;
      end
   end

   assign wb_dat_o  = dat_q;
   assign pending_o = pending;

endmodule

// File: tb/tb_int_vector_responder.sv
// Randomised scoreboard bench for int_vector_responder: stimulus tasks push expected vectors,
// an independent monitor pops them whenever the responder acknowledges.
module tb_int_vector_responder;

   localparam logic [7:0] VB = 8'h40;
   localparam logic [6:0] AV = 7'b1010000;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] irq_v = '0;
   logic       cyc   = 1'b0;
   logic       stb   = 1'b0;
   logic       iack  = 1'b0;
   logic [2:0] adr   = '0;
   logic [7:0] dat;
   logic       ack;
   logic [6:0] pend;

   int         n_cmp   = 0;
   int         n_err   = 0;
   int         ack_cnt = 0;
   logic [7:0] exp_q[$];
   logic [6:0] m_pend  = '0;
   logic [6:0] av_v    = AV;

   always #5 clk = ~clk;

   int_vector_responder #(
      .VECTOR_BASE (VB),
      .AUTOVEC     (AV)
   ) dut (
      .wb_clk_i    (clk),
      .wb_reset_ni (rst_n),
      .irq_i       (irq_v),
      .wb_cyc_i    (cyc),
      .wb_stb_i    (stb),
      .wb_iack_i   (iack),
      .wb_adr_i    (adr),
      .wb_dat_o    (dat),
      .wb_ack_o    (ack),
      .pending_o   (pend)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference vector straight from the level rules.
   function automatic logic [7:0] ref_vec(input int lvl, input logic [6:0] p);
      if (lvl < 1 || lvl > 7) return 8'h18;
      if (!p[lvl-1]) return 8'h18;
      if (av_v[lvl-1]) return 8'((24 + lvl) % 256);
      return 8'((int'(VB) + lvl - 1) % 256);
   endfunction

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         ack_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(dat), 32'hFFFF_FFFF);
         end else begin
            check("vector", 32'(dat), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic pulse(input int b);
      @(posedge clk); #1;
      if (!irq_v[b]) m_pend[b] = 1'b1;
      irq_v[b] = 1'b1;
      @(posedge clk); #1;
      irq_v[b] = 1'b0;
   endtask

   task automatic do_iack(input int lvl, input int hold, input bit abort,
                          input logic [6:0] rise_in_ack, input string tag);
      logic [7:0] e;
      logic [6:0] rises;
      bit         hit;
      int         a0;
      hit = 1'b0;
      if (lvl >= 1) hit = m_pend[lvl-1];
      e  = ref_vec(lvl, m_pend);
      a0 = ack_cnt;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; iack = 1'b1; adr = 3'(lvl);
      @(negedge clk);
      check({tag, "_early_ack"}, 32'(ack), 32'd0);
      @(posedge clk); #1;
      rises = rise_in_ack & ~irq_v;
      irq_v = irq_v | rise_in_ack;
      if (abort) begin
         cyc = 1'b0; stb = 1'b0;
      end else begin
         exp_q.push_back(e);
      end
      @(negedge clk);
      check({tag, "_ack"}, 32'(ack), abort ? 32'd0 : 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check({tag, "_hold_noack"}, 32'(ack), 32'd0);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; iack = 1'b0; adr = '0; irq_v = '0;
      if (!abort && hit) m_pend[lvl-1] = 1'b0;
      m_pend = m_pend | rises;
      @(posedge clk); #1;
      check({tag, "_ack_count"}, 32'(ack_cnt - a0), abort ? 32'd0 : 32'd1);
      check({tag, "_pending"}, 32'(pend), 32'(m_pend));
   endtask

   task automatic non_iack(input logic [2:0] a);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; iack = 1'b0; adr = a;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("noniack_ack", 32'(ack), 32'd0);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; adr = '0;
      @(posedge clk); #1;
      check("noniack_pending", 32'(pend), 32'(m_pend));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] e;
      int         r;

      // Reset with all requests held high.
      irq_v = 7'h7F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_pending", 32'(pend), 32'd0);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_dat", 32'(dat), 32'd0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      m_pend = 7'h7F;
      @(posedge clk); #1;
      check("release_pending", 32'(pend), 32'h7F);
      irq_v = '0;

      for (int l = 1; l <= 7; l++) do_iack(l, 0, 1'b0, 7'h00, "drain");

      // Vectored level 3.
      pulse(2);
      @(posedge clk); #1;
      check("lvl3_pending", 32'(pend), 32'h04);
      do_iack(3, 0, 1'b0, 7'h00, "lvl3");

      // Autovectored level 7.
      pulse(6);
      do_iack(7, 0, 1'b0, 7'h00, "auto7");

      // Spurious cases.
      do_iack(5, 0, 1'b0, 7'h00, "spur5");
      do_iack(0, 0, 1'b0, 7'h00, "spur0");

      // New edge on the level being acknowledged survives the clear.
      pulse(2);
      do_iack(3, 0, 1'b0, 7'h04, "setwins");
      do_iack(3, 0, 1'b0, 7'h00, "setwins_drain");

      // Long strobe, then an aborted cycle.
      pulse(4);
      do_iack(5, 3, 1'b0, 7'h00, "longstb");
      pulse(1);
      do_iack(2, 0, 1'b1, 7'h00, "abort");
      do_iack(2, 0, 1'b0, 7'h00, "after_abort");

      non_iack(3'd4);

      // Reset while in the ack state.
      pulse(1);
      e = ref_vec(2, m_pend);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; iack = 1'b1; adr = 3'd2;
      @(posedge clk); #1;
      exp_q.push_back(e);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_ack_ack", 32'(ack), 32'd1);
      @(posedge clk); #1;
      m_pend = '0;
      @(negedge clk);
      check("rst_ack_drop", 32'(ack), 32'd0);
      check("rst_pending_lost", 32'(pend), 32'd0);
      check("rst_dat", 32'(dat), 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; iack = 1'b0; adr = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_pending", 32'(pend), 32'd0);

      // Randomised mix.
      for (int it = 0; it < 150; it++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 3) begin
            pulse(int'($urandom_range(0, 6)));
         end else if (r <= 7) begin
            do_iack(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00, "rnd");
         end else begin
            non_iack(3'($urandom));
         end
      end

      repeat (3) @(posedge clk);
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
